// File: rtl/div_operand_seq.sv
`default_nettype none
// ============================================================================
// Module   : div_operand_seq
// Purpose  : Operand sequencer for the unsigned restoring divider. Captures a
//            signed dividend and divisor on two load events and sends their
//            magnitudes to the divider. It then waits for Ready, applies sign
//            correction, and flags divide-by-zero, overflow and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module div_operand_seq #(
  parameter int DW      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] data_in,
  input  logic          div_ready,
  input  logic [DW-1:0] div_result,
  input  logic [DW-1:0] div_remainder,
  output logic [DW-1:0] dividendo,
  output logic [DW-1:0] divisor,
  output logic          div_start,
  output logic [DW-1:0] result,
  output logic [DW-1:0] remainder,
  output logic          done,
  output logic          error,
  output logic          load_x,
  output logic          load_y
);

  // Timeout counter only has to reach TIMEOUT-1
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] c_TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT_Y = 3'd1,
    S_CHECK  = 3'd2,
    S_START  = 3'd3,
    S_WAIT   = 3'd4,
    S_FIX    = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_load_d;
  logic          w_load_evt;
  logic [DW-1:0] r_x;
  logic [DW-1:0] r_y;
  logic          r_neg_q;
  logic          r_neg_r;
  logic [TW-1:0] r_tmo;
  logic [DW-1:0] r_q;
  logic [DW-1:0] r_r;
  logic [DW-1:0] r_dividendo;
  logic [DW-1:0] r_divisor;
  logic [DW-1:0] r_result;
  logic [DW-1:0] r_remainder;
  logic [DW-1:0] w_x_mag;
  logic [DW-1:0] w_y_mag;
  logic [DW-1:0] w_q_signed;
  logic [DW-1:0] w_r_signed;
  logic          w_ovf;

  assign w_load_evt = load & ~r_load_d;

  // Negating the most negative value wraps back to 2^(DW-1), which is the
  // correct unsigned magnitude.
  assign w_x_mag = r_x[DW-1] ? -r_x : r_x;
  assign w_y_mag = r_y[DW-1] ? -r_y : r_y;

  // The remainder takes the dividend's sign, but zero stays zero
  assign w_q_signed = r_neg_q ? -r_q : r_q;
  assign w_r_signed = (r_neg_r && (r_r != '0)) ? -r_r : r_r;
  // A positive quotient of 2^(DW-1) cannot be represented
  assign w_ovf      = ~r_neg_q & r_q[DW-1];

  assign dividendo = r_dividendo;
  assign divisor   = r_divisor;
  assign result    = r_result;
  assign remainder = r_remainder;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    w_state_nxt = r_state;
    div_start   = 1'b0;
    done        = 1'b0;
    error       = 1'b0;
    load_x      = 1'b0;
    load_y      = 1'b0;
    case (r_state)
      S_IDLE: begin
        load_x = 1'b1;
        if (w_load_evt) w_state_nxt = S_WAIT_Y;
      end
      S_WAIT_Y: begin
        load_y = 1'b1;
        if (w_load_evt) w_state_nxt = S_CHECK;
      end
      S_CHECK: w_state_nxt = (r_y == '0) ? S_ERR : S_START;
      S_START: begin
        div_start   = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (div_ready)                w_state_nxt = S_FIX;
        else if (r_tmo == c_TMO_LAST) w_state_nxt = S_ERR;
      end
      S_FIX: w_state_nxt = w_ovf ? S_ERR : S_DONE;
      S_DONE: begin
        done = 1'b1;
        if (w_load_evt) w_state_nxt = S_WAIT_Y;
      end
      S_ERR: begin
        error = 1'b1;
        if (w_load_evt) w_state_nxt = S_WAIT_Y;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, divider handshake data and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_d    <= 1'b0;
      r_x         <= '0;
      r_y         <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_tmo       <= '0;
      r_q         <= '0;
      r_r         <= '0;
      r_dividendo <= '0;
      r_divisor   <= '0;
      r_result    <= '0;
      r_remainder <= '0;
    end else begin
      r_load_d <= load;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (w_load_evt) r_x <= data_in;
        end
        S_WAIT_Y: begin
          if (w_load_evt) r_y <= data_in;
        end
        S_CHECK: begin
          if (r_y != '0) begin
            r_dividendo <= w_x_mag;
            r_divisor   <= w_y_mag;
            r_neg_q     <= r_x[DW-1] ^ r_y[DW-1];
            r_neg_r     <= r_x[DW-1];
          end
        end
        S_START: r_tmo <= '0;
        S_WAIT: begin
          if (div_ready) begin
            r_q <= div_result;
            r_r <= div_remainder;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_FIX: begin
          r_result    <= w_q_signed;
          r_remainder <= w_r_signed;
        end
        default: ;
      endcase
      // Every path into the error state presents zeroed results
      if ((w_state_nxt == S_ERR) && (r_state != S_ERR)) begin
        r_result    <= '0;
        r_remainder <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_operand_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_operand_seq
// Purpose  : Directed scoreboard bench for div_operand_seq with a behavioural
//            divider model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_operand_seq;

  localparam int DW      = 16;
  localparam int TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [DW-1:0] data_in;
  logic          div_ready;
  logic [DW-1:0] div_result;
  logic [DW-1:0] div_remainder;
  logic [DW-1:0] dividendo;
  logic [DW-1:0] divisor;
  logic          div_start;
  logic [DW-1:0] result;
  logic [DW-1:0] remainder;
  logic          done;
  logic          error;
  logic          load_x;
  logic          load_y;

  div_operand_seq #(.DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .data_in      (data_in),
    .div_ready    (div_ready),
    .div_result   (div_result),
    .div_remainder(div_remainder),
    .dividendo    (dividendo),
    .divisor      (divisor),
    .div_start    (div_start),
    .result       (result),
    .remainder    (remainder),
    .done         (done),
    .error        (error),
    .load_x       (load_x),
    .load_y       (load_y)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          err;
    logic [DW-1:0] res;
    logic [DW-1:0] rem;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  // divider model state
  int            lat = 3;
  logic          hang = 1'b0;
  logic          pend = 1'b0;
  int            cnt = 0;
  logic [DW-1:0] m_q, m_r;
  int            n_start = 0;
  int            start_cyc = 0;
  int            ready_cyc = 0;

  // monitor state
  logic          prev_de = 1'b0;
  int            err_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural divider: Ready stays high between operations (stale result)
  initial begin
    div_ready     = 1'b1;
    div_result    = 16'hBEEF;
    div_remainder = 16'h0BAD;
  end

  always @(negedge clk) begin
    if (div_start) begin
      pend      = 1'b1;
      n_start   = n_start + 1;
      start_cyc = cyc;
    end else if (pend) begin
      pend      = 1'b0;
      div_ready = 1'b0;
      if (divisor == '0) begin
        m_q = '1;
        m_r = dividendo;
      end else begin
        m_q = dividendo / divisor;
        m_r = dividendo % divisor;
      end
      cnt = lat;
    end else if (!div_ready && cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0 && !hang) begin
        div_ready     = 1'b1;
        div_result    = m_q;
        div_remainder = m_r;
        ready_cyc     = cyc;
      end
    end
  end

  // Monitor: compare whenever done or error rises
  always @(negedge clk) begin
    if ((done || error) && !prev_de) begin
      if (error) err_cyc = cyc;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected", {done, error}, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("res", result, e.res);
        chk("rem", remainder, e.rem);
        chk("err_flag", {error, done}, {e.err, ~e.err});
        if (done) chk("rdy2done", cyc - ready_cyc, 2);
      end
    end
    prev_de = done | error;
  end

  task automatic run_div(input logic [DW-1:0] x, input logic [DW-1:0] y,
                         input logic e_err, input logic [DW-1:0] e_res,
                         input logic [DW-1:0] e_rem, input int hold_x);
    int   n;
    int   s0;
    exp_t e;
    n = 0;
    while (!(load_x || done || error) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", (n >= 200), 0);
    e.err = e_err;
    e.res = e_res;
    e.rem = e_rem;
    sb_q.push_back(e);
    s0 = n_start;
    data_in = x;
    load    = 1'b1;
    repeat (hold_x) @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    chk("wait_y", {load_y, load_x, error, done}, 4'b1000);
    data_in = y;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("check_cyc", {div_start, error, done}, 0);
    @(negedge clk);
    if (y == '0) chk("dz_lat", {error, div_start}, 2'b10);
    else         chk("start_lat", {div_start, error}, 2'b10);
    n = 0;
    while (!(done || error) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("op_wait", (n >= 200), 0);
    @(negedge clk);
    chk("n_start", n_start - s0, (y != '0) ? 1 : 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst     = 1'b1;
    load    = 1'b0;
    data_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {load_x, load_y, done, error, div_start}, 5'b10000);
    chk("rst_data", {result, remainder}, 0);
    chk("rst_ops", {dividendo, divisor}, 0);
    rst = 1'b0;
    @(negedge clk);

    run_div(16'd100, 16'd7, 1'b0, 16'h000E, 16'h0002, 1);
    run_div(16'hFF9C, 16'd7, 1'b0, 16'hFFF2, 16'hFFFE, 1);   // -100 / 7
    chk("mag_x", dividendo, 16'd100);
    chk("mag_y", divisor, 16'd7);
    run_div(16'd100, 16'hFFF9, 1'b0, 16'hFFF2, 16'h0002, 1); // 100 / -7
    chk("mag_y_neg", divisor, 16'd7);
    run_div(16'hFF9C, 16'hFFF9, 1'b0, 16'h000E, 16'hFFFE, 1); // -100 / -7
    run_div(16'hFFF9, 16'd100, 1'b0, 16'h0000, 16'hFFF9, 1);  // -7 / 100
    run_div(16'd5, 16'd0, 1'b1, 16'h0000, 16'h0000, 1);       // divide by zero
    run_div(16'h8000, 16'hFFFF, 1'b1, 16'h0000, 16'h0000, 1); // overflow
    chk("mag_min", {dividendo, divisor}, {16'h8000, 16'h0001});
    run_div(16'h8000, 16'h0001, 1'b0, 16'h8000, 16'h0000, 1);

    // Divider never answers; dividend load held for 10 cycles
    hang = 1'b1;
    run_div(16'd9, 16'd3, 1'b1, 16'h0000, 16'h0000, 10);
    chk("tmo_cycles", err_cyc - start_cyc, TIMEOUT + 1);
    hang = 1'b0;
    run_div(16'd6, 16'd3, 1'b0, 16'h0002, 16'h0000, 1);

    // Reset in the middle of WAIT, then a late Ready must be ignored
    lat = 20;
    data_in = 16'd50;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    data_in = 16'd5;
    load    = 1'b1;
    @(negedge clk);
    load = 1'b0;
    n = 0;
    while (!div_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_test_start", (n >= 20), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ctl", {load_x, load_y, done, error, div_start}, 5'b10000);
    chk("midrst_data", {result, remainder, dividendo, divisor}, 0);
    repeat (25) @(negedge clk);
    chk("stale_rdy", {load_x, done, error, div_start}, 4'b1000);
    lat = 3;
    run_div(16'hFFEC, 16'd6, 1'b0, 16'hFFFD, 16'hFFFE, 1);    // -20 / 6

    chk("sb_left", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
